// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencer for a downstream 4-bit up/down counter.
// It loads a seed, then issues count enables (up, down or ping-pong)
// until the fed-back counter value reaches the captured terminal value.
// Pause freezes counting, stop aborts the run, and clear is a synchronous
// active-low reset. All outputs decode combinationally from the state
// register, the captured registers and A_count, so they carry no extra latency.

module counter_ctrl (
   input  logic       clk,
   input  logic       clear,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic [1:0] mode,
   input  logic [3:0] seed,
   input  logic [3:0] limit,
   input  logic [3:0] A_count,
   output logic [3:0] data_out,
   output logic       load,
   output logic       count,
   output logic       updown,
   output logic       busy,
   output logic       done,
   output logic [7:0] steps
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_RUN_UP   = 3'd2,
      S_RUN_DOWN = 3'd3,
      S_HOLD     = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_PING = 2'b10;

   state_t     state_q;
   logic [1:0] mode_q;
   logic [3:0] seed_q;
   logic [3:0] limit_q;
   logic [7:0] steps_q;
   logic       dir_q;      // direction saved on entry to HOLD, 1 = down
   logic [7:0] steps_d;
   logic       load_s;
   logic       count_s;
   logic       updown_s;
   logic       up_term_s;
   logic       dn_term_s;

   assign up_term_s = (A_count == limit_q);
   assign dn_term_s = (A_count == 4'd0);

   // Decode counter controls from the current state and the fed-back count.
   always_comb begin
      load_s   = 1'b0;
      count_s  = 1'b0;
      updown_s = 1'b0;
      case (state_q)
         S_LOAD: begin
            load_s = 1'b1;
         end
         S_RUN_UP: begin
            updown_s = 1'b0;
            count_s  = ~up_term_s;
         end
         S_RUN_DOWN: begin
            updown_s = 1'b1;
            count_s  = ~dn_term_s;
         end
         S_HOLD: begin
            updown_s = dir_q;
         end
         default: begin
            load_s   = 1'b0;
            count_s  = 1'b0;
            updown_s = 1'b0;
         end
      endcase
   end

   // Saturating step counter increment, taken only when a count enable is issued.
   always_comb begin
      if (count_s && (steps_q != 8'hFF)) begin
         steps_d = steps_q + 8'd1;
      end else begin
         steps_d = steps_q;
      end
   end

   // Sequencer state machine with capture registers and step counter.
   always_ff @(posedge clk) begin
      if (!clear) begin
         state_q <= S_IDLE;
         mode_q  <= 2'b00;
         seed_q  <= 4'd0;
         limit_q <= 4'd0;
         steps_q <= 8'd0;
         dir_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !stop) begin
                  mode_q  <= mode;
                  seed_q  <= seed;
                  limit_q <= limit;
                  steps_q <= 8'd0;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (stop) begin
                  state_q <= S_IDLE;
               end else begin
                  case (mode_q)
                     MODE_UP:   state_q <= S_RUN_UP;
                     MODE_PING: state_q <= S_RUN_UP;
                     MODE_DOWN: state_q <= S_RUN_DOWN;
                     default:   state_q <= S_DONE;
                  endcase
               end
            end
            S_RUN_UP: begin
               steps_q <= steps_d;
               if (stop) begin
                  state_q <= S_IDLE;
               end else if (pause) begin
                  dir_q   <= 1'b0;
                  state_q <= S_HOLD;
               end else if (up_term_s) begin
                  // A zero-count cycle at the terminal value is the reversal dwell.
                  state_q <= (mode_q == MODE_PING) ? S_RUN_DOWN : S_DONE;
               end
            end
            S_RUN_DOWN: begin
               steps_q <= steps_d;
               if (stop) begin
                  state_q <= S_IDLE;
               end else if (pause) begin
                  dir_q   <= 1'b1;
                  state_q <= S_HOLD;
               end else if (dn_term_s) begin
                  state_q <= (mode_q == MODE_PING) ? S_RUN_UP : S_DONE;
               end
            end
            S_HOLD: begin
               if (stop) begin
                  state_q <= S_IDLE;
               end else if (!pause) begin
                  state_q <= dir_q ? S_RUN_DOWN : S_RUN_UP;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign data_out = seed_q;
   assign load     = load_s;
   assign count    = count_s;
   assign updown   = updown_s;
   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign steps    = steps_q;

endmodule
